// File: rtl/window_scan_controller_pkg.sv
// Shared definitions for the Sobel window sequencer: shift codes,
// controller state encodings and the empty-slot substitution helper.
package sobel_pkg;

  localparam logic [1:0] SHIFT_NONE  = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;
  localparam logic [1:0] SHIFT_DOWN  = 2'b11;

  // The window buffer reads zero as an empty slot.
  localparam logic [7:0] ZERO_SUBST = 8'd1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_INIT     = 3'd1;
  localparam logic [2:0] ST_FETCH    = 3'd2;
  localparam logic [2:0] ST_WAIT_MEM = 3'd3;
  localparam logic [2:0] ST_LOAD     = 3'd4;
  localparam logic [2:0] ST_PRESENT  = 3'd5;
  localparam logic [2:0] ST_SHIFT    = 3'd6;
  localparam logic [2:0] ST_DONE     = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_INIT     = ST_INIT,
    S_FETCH    = ST_FETCH,
    S_WAIT_MEM = ST_WAIT_MEM,
    S_LOAD     = ST_LOAD,
    S_PRESENT  = ST_PRESENT,
    S_SHIFT    = ST_SHIFT,
    S_DONE     = ST_DONE
  } scan_state_t;

  function automatic logic [7:0] subst_zero(input logic [7:0] d);
    return (d == 8'd0) ? ZERO_SUBST : d;
  endfunction

endpackage

// File: rtl/window_scan_controller_if.sv
// Pixel memory, window buffer and gradient-stage signals of the scan controller.
interface window_scan_controller_if #(
  parameter int ADDR_W = 16,
  parameter int X_W    = 4,
  parameter int Y_W    = 4
);

  logic              mem_ren;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [7:0]        mem_rdata;
  logic              start_read;
  logic [7:0]        data_r;
  logic              read_done;
  logic              start_shift;
  logic [1:0]        shift_direc;
  logic              shift_done;
  logic              win_valid;
  logic              win_ack;
  logic [X_W-1:0]    win_x;
  logic [Y_W-1:0]    win_y;

  modport master (
    output mem_ren, mem_addr, start_read, data_r, start_shift, shift_direc,
           win_valid, win_x, win_y,
    input  mem_rvalid, mem_rdata, read_done, shift_done, win_ack
  );

  modport slave (
    input  mem_ren, mem_addr, start_read, data_r, start_shift, shift_direc,
           win_valid, win_x, win_y,
    output mem_rvalid, mem_rdata, read_done, shift_done, win_ack
  );

endinterface

// File: rtl/window_scan_controller_scan_addr_gen.sv
// Pixel address for one buffer fill step: full 9-pixel load or a
// 3-pixel refill after a LEFT/RIGHT/DOWN shift, in slot order.
module scan_addr_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int ADDR_W = 16,
  parameter int X_W    = 4,
  parameter int Y_W    = 4
) (
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic [1:0]        kind,
  input  logic [3:0]        idx,
  output logic [ADDR_W-1:0] addr
);

  logic [1:0] row_off;
  logic [1:0] col_off;
  logic [3:0] idx_m3;
  logic [3:0] idx_m6;

  assign idx_m3 = idx - 4'd3;
  assign idx_m6 = idx - 4'd6;

  // Translate fill kind and index into a row/column offset from (x, y).
  always_comb begin
    row_off = '0;
    col_off = '0;
    case (kind)
      SHIFT_LEFT: begin
        row_off = idx[1:0];
        col_off = 2'd2;
      end
      SHIFT_RIGHT: begin
        row_off = idx[1:0];
        col_off = 2'd0;
      end
      SHIFT_DOWN: begin
        row_off = 2'd0;
        col_off = idx[1:0];
      end
      default: begin
        if (idx >= 4'd6) begin
          row_off = 2'd2;
          col_off = idx_m6[1:0];
        end else if (idx >= 4'd3) begin
          row_off = 2'd1;
          col_off = idx_m3[1:0];
        end else begin
          row_off = 2'd0;
          col_off = idx[1:0];
        end
      end
    endcase
  end

  assign addr = (ADDR_W'(y) + ADDR_W'(row_off)) * ADDR_W'(IMG_W)
              + ADDR_W'(x) + ADDR_W'(col_off);

endmodule

// File: rtl/window_scan_controller.sv
// Serpentine window sequencer: clears and loads the 3x3 window buffer from
// pixel memory, presents each window, then shifts it to the next position.
module window_scan_controller
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic go,
  output logic busy,
  output logic frame_done,
  window_scan_controller_if.master bus
);

  localparam int X_W = $clog2(IMG_W);
  localparam int Y_W = $clog2(IMG_H);
  localparam logic [X_W-1:0] X_LAST  = X_W'(IMG_W - 3);
  localparam logic [Y_W-1:0] Y_START = Y_W'(IMG_H - 3);

  scan_state_t    state;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           dir_pos;
  logic [1:0]     fill_kind;
  logic [3:0]     fill_idx;
  logic [1:0]     init_cnt;
  logic [1:0]     init_phase;
  logic [7:0]     data_q;
  logic [1:0]     code_q;

  logic [3:0]     fill_last;
  logic           at_row_end;
  logic           last_win;
  logic [1:0]     next_code;

  assign fill_last  = (fill_kind == SHIFT_NONE) ? 4'd8 : 4'd2;
  assign at_row_end = dir_pos ? (x == X_LAST) : (x == '0);
  assign last_win   = at_row_end && (y == '0);
  assign next_code  = at_row_end ? SHIFT_DOWN : (dir_pos ? SHIFT_LEFT : SHIFT_RIGHT);

  scan_addr_gen #(
    .IMG_W (IMG_W),
    .ADDR_W(ADDR_W),
    .X_W   (X_W),
    .Y_W   (Y_W)
  ) u_addr_gen (
    .x   (x),
    .y   (y),
    .kind(fill_kind),
    .idx (fill_idx),
    .addr(bus.mem_addr)
  );

  assign busy            = (state != S_IDLE);
  assign frame_done      = (state == S_DONE);
  assign bus.mem_ren     = (state == S_FETCH);
  assign bus.start_read  = (state == S_LOAD);
  assign bus.start_shift = (state == S_SHIFT) || ((state == S_INIT) && (init_phase == 2'd0));
  assign bus.shift_direc = code_q;
  assign bus.data_r      = data_q;
  assign bus.win_valid   = (state == S_PRESENT);
  assign bus.win_x       = x;
  assign bus.win_y       = y;

  // Scan sequencing: state, window position, fill progress and latched pixel.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      x          <= '0;
      y          <= '0;
      dir_pos    <= 1'b0;
      fill_kind  <= SHIFT_NONE;
      fill_idx   <= '0;
      init_cnt   <= '0;
      init_phase <= '0;
      data_q     <= '0;
      code_q     <= SHIFT_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            state      <= S_INIT;
            x          <= '0;
            y          <= Y_START;
            dir_pos    <= 1'b1;
            fill_kind  <= SHIFT_NONE;
            fill_idx   <= '0;
            init_cnt   <= '0;
            init_phase <= '0;
            code_q     <= SHIFT_DOWN;
          end
        end
        // Each clearing shift spans request, release and a guard cycle so the
        // buffer acknowledge has dropped before the next request is raised.
        S_INIT: begin
          if (init_phase == 2'd0) begin
            if (bus.shift_done) init_phase <= 2'd1;
          end else if (init_phase == 2'd1) begin
            init_phase <= 2'd2;
          end else begin
            init_phase <= 2'd0;
            if (init_cnt == 2'd2) begin
              init_cnt <= '0;
              state    <= S_FETCH;
            end else begin
              init_cnt <= init_cnt + 2'd1;
            end
          end
        end
        S_FETCH: state <= S_WAIT_MEM;
        S_WAIT_MEM: begin
          if (bus.mem_rvalid) begin
            data_q <= subst_zero(bus.mem_rdata);
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.read_done) begin
            if (fill_idx == fill_last) begin
              fill_idx <= '0;
              state    <= S_PRESENT;
            end else begin
              fill_idx <= fill_idx + 4'd1;
              state    <= S_FETCH;
            end
          end
        end
        S_PRESENT: begin
          if (bus.win_ack) begin
            if (last_win) begin
              state <= S_DONE;
            end else begin
              code_q <= next_code;
              if (next_code == SHIFT_DOWN) dir_pos <= ~dir_pos;
              state  <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          if (bus.shift_done) begin
            case (code_q)
              SHIFT_LEFT:  x <= x + X_W'(1);
              SHIFT_RIGHT: x <= x - X_W'(1);
              default:     y <= y - Y_W'(1);
            endcase
            fill_kind <= code_q;
            fill_idx  <= '0;
            state     <= S_FETCH;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_scan_controller.sv
// Directed bench for window_scan_controller: a 3x3 frame with cycle count,
// a 4x4 serpentine frame driven from vector tables, backpressure and reset.
module tb_window_scan_controller;
  import sobel_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       n_rst, go3, go4, rvalid, read_done, shift_done, win_ack, sel;
  logic [7:0] rdata;
  logic       busy3, busy4, fd3, fd4;

  window_scan_controller_if #(.ADDR_W(16), .X_W(2), .Y_W(2)) if3 ();
  window_scan_controller_if #(.ADDR_W(16), .X_W(2), .Y_W(2)) if4 ();

  assign if3.mem_rvalid = rvalid;
  assign if3.mem_rdata  = rdata;
  assign if3.read_done  = read_done;
  assign if3.shift_done = shift_done;
  assign if3.win_ack    = win_ack;
  assign if4.mem_rvalid = rvalid;
  assign if4.mem_rdata  = rdata;
  assign if4.read_done  = read_done;
  assign if4.shift_done = shift_done;
  assign if4.win_ack    = win_ack;

  window_scan_controller #(.IMG_W(3), .IMG_H(3), .ADDR_W(16)) dut3 (
    .clk(clk), .n_rst(n_rst), .go(go3), .busy(busy3), .frame_done(fd3), .bus(if3.master)
  );
  window_scan_controller #(.IMG_W(4), .IMG_H(4), .ADDR_W(16)) dut4 (
    .clk(clk), .n_rst(n_rst), .go(go4), .busy(busy4), .frame_done(fd4), .bus(if4.master)
  );

  // sel = 1 observes the 3x3 instance, 0 the 4x4 instance
  wire        c_busy = sel ? busy3 : busy4;
  wire        c_fd   = sel ? fd3 : fd4;
  wire        c_ren  = sel ? if3.mem_ren : if4.mem_ren;
  wire [15:0] c_addr = sel ? if3.mem_addr : if4.mem_addr;
  wire        c_srd  = sel ? if3.start_read : if4.start_read;
  wire [7:0]  c_data = sel ? if3.data_r : if4.data_r;
  wire        c_ssh  = sel ? if3.start_shift : if4.start_shift;
  wire [1:0]  c_dir  = sel ? if3.shift_direc : if4.shift_direc;
  wire        c_wv   = sel ? if3.win_valid : if4.win_valid;
  wire [3:0]  c_x    = sel ? {2'b00, if3.win_x} : {2'b00, if4.win_x};
  wire [3:0]  c_y    = sel ? {2'b00, if3.win_y} : {2'b00, if4.win_y};

  typedef struct {
    logic [7:0]  rdata;
    logic [15:0] addr;
    logic [7:0]  data;
    int          lat;
    int          hold;
  } vec_t;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    int         ack_dly;
    logic [1:0] next_code;
  } win_t;

  vec_t v4[18];
  win_t w4[4];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit flag(input int k);
    case (k)
      0:       return c_ren === 1'b1;
      1:       return c_srd === 1'b1;
      2:       return c_ssh === 1'b1;
      3:       return c_wv === 1'b1;
      default: return c_fd === 1'b1;
    endcase
  endfunction

  task automatic wait_flag(input int k, input string name, input int budget);
    int n = 0;
    while (!flag(k) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!flag(k)) chk({name, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_pixel(input vec_t v, input string tag);
    wait_flag(0, {tag, " mem_ren"}, 40);
    chk({tag, " addr"}, c_addr, v.addr);
    repeat (v.lat) @(negedge clk);
    rvalid = 1'b1;
    rdata  = v.rdata;
    @(negedge clk);
    rvalid = 1'b0;
    chk({tag, " start_read"}, c_srd, 1);
    chk({tag, " data_r"}, c_data, v.data);
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk({tag, " held start_read/data_r"}, {c_srd, c_data}, {1'b1, v.data});
    end
    read_done = 1'b1;
    @(negedge clk);
    read_done = 1'b0;
    chk({tag, " start_read released"}, c_srd, 0);
  endtask

  task automatic do_shift(input logic [1:0] code, input string tag);
    wait_flag(2, {tag, " start_shift"}, 40);
    chk({tag, " shift_direc"}, c_dir, code);
    shift_done = 1'b1;
    @(negedge clk);
    shift_done = 1'b0;
    chk({tag, " start_shift released"}, c_ssh, 0);
  endtask

  task automatic do_window(input win_t w, input string tag);
    wait_flag(3, {tag, " win_valid"}, 40);
    chk({tag, " win_x"}, c_x, w.x);
    chk({tag, " win_y"}, c_y, w.y);
    for (int i = 0; i < w.ack_dly; i++) begin
      @(negedge clk);
      chk({tag, " held win/no ren"}, {c_wv, c_ren, c_x, c_y}, {1'b1, 1'b0, w.x, w.y});
    end
    win_ack = 1'b1;
    @(negedge clk);
    win_ack = 1'b0;
    chk({tag, " win_valid released"}, c_wv, 0);
  endtask

  task automatic start_frame(input string tag);
    if (sel) go3 = 1'b1;
    else     go4 = 1'b1;
    @(negedge clk);
    go3 = 1'b0;
    go4 = 1'b0;
    chk({tag, " busy after go"}, c_busy, 1);
    chk({tag, " first start_shift"}, c_ssh, 1);
    chk({tag, " first code"}, c_dir, SHIFT_DOWN);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned a4[18];
    int unsigned t0;
    int vi;
    vec_t p;

    a4 = '{4, 5, 6, 8, 9, 10, 12, 13, 14, 7, 11, 15, 1, 2, 3, 0, 4, 8};
    for (int i = 0; i < 18; i++) begin
      v4[i].addr = 16'(a4[i]);
      v4[i].rdata = 8'(8'h30 + i);
      v4[i].data = v4[i].rdata;
      v4[i].lat = (i == 4) ? 3 : 1;
      v4[i].hold = (i == 2) ? 5 : 0;
    end
    v4[0].rdata = 8'h00; v4[0].data = 8'h01;
    v4[1].rdata = 8'hFF; v4[1].data = 8'hFF;
    w4[0] = '{x: 4'd0, y: 4'd1, ack_dly: 0,  next_code: SHIFT_LEFT};
    w4[1] = '{x: 4'd1, y: 4'd1, ack_dly: 10, next_code: SHIFT_DOWN};
    w4[2] = '{x: 4'd1, y: 4'd0, ack_dly: 0,  next_code: SHIFT_RIGHT};
    w4[3] = '{x: 4'd0, y: 4'd0, ack_dly: 0,  next_code: SHIFT_NONE};

    // Reset with go held high: nothing may respond.
    sel = 1'b0; n_rst = 1'b0; go3 = 1'b1; go4 = 1'b1;
    rvalid = 1'b0; rdata = 8'h00; read_done = 1'b0; shift_done = 1'b0; win_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst busy", c_busy, 0);
    chk("rst frame_done", c_fd, 0);
    chk("rst mem_ren/addr", {c_ren, c_addr}, 0);
    chk("rst start_read/data_r", {c_srd, c_data}, 0);
    chk("rst start_shift/direc", {c_ssh, c_dir}, 0);
    chk("rst win_valid/x/y", {c_wv, c_x, c_y}, 0);
    chk("rst busy 3x3", busy3, 0);
    go3 = 1'b0; go4 = 1'b0; n_rst = 1'b1;
    @(negedge clk);
    chk("go during reset ignored", {busy3, busy4, c_ssh}, 0);

    // 3x3 frame: single window, 38-cycle go-to-frame_done latency.
    sel = 1'b1;
    t0 = cyc;
    start_frame("3x3");
    for (int i = 0; i < 3; i++) do_shift(SHIFT_DOWN, $sformatf("3x3 clr%0d", i));
    for (int i = 0; i < 9; i++) begin
      p.addr = 16'(i); p.rdata = 8'(8'h20 + i); p.data = p.rdata; p.lat = 1; p.hold = 0;
      do_pixel(p, $sformatf("3x3 px%0d", i));
    end
    do_window('{x: 4'd0, y: 4'd0, ack_dly: 0, next_code: SHIFT_NONE}, "3x3 win");
    wait_flag(4, "3x3 frame_done", 10);
    chk("3x3 go-to-frame_done cycles", cyc - t0, 38);
    @(negedge clk);
    chk("3x3 idle after frame", {c_busy, c_fd}, 0);

    // 4x4: reset while waiting on memory, then a late rvalid.
    sel = 1'b0;
    start_frame("4x4a");
    for (int i = 0; i < 3; i++) do_shift(SHIFT_DOWN, $sformatf("4x4a clr%0d", i));
    wait_flag(0, "4x4a mem_ren", 40);
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    chk("rst in WAIT_MEM busy", c_busy, 0);
    chk("rst in WAIT_MEM outputs", {c_ren, c_srd, c_ssh, c_wv}, 0);
    n_rst = 1'b1; rvalid = 1'b1; rdata = 8'h55;
    @(negedge clk);
    rvalid = 1'b0;
    chk("late rvalid ignored", {c_busy, c_srd}, 0);

    // 4x4 full serpentine frame from the vector tables.
    start_frame("4x4");
    for (int i = 0; i < 3; i++) do_shift(SHIFT_DOWN, $sformatf("4x4 clr%0d", i));
    vi = 0;
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < ((w == 0) ? 9 : 3); k++) begin
        do_pixel(v4[vi], $sformatf("4x4 v%0d", vi));
        vi++;
      end
      do_window(w4[w], $sformatf("4x4 win%0d", w));
      if (w4[w].next_code != SHIFT_NONE) do_shift(w4[w].next_code, $sformatf("4x4 sh%0d", w));
    end
    wait_flag(4, "4x4 frame_done", 10);
    @(negedge clk);
    chk("4x4 idle after frame", {c_busy, c_fd}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
